memory_port: RTL and testbench

Multicycle memory front end between the shared instruction/data memory and the multicycle controller/datapath. Captures a one-cycle read or write request, performs it as four byte-wide beats over an 8-bit external handshake bus, and holds the results:

- On reads, it assembles the 32-bit word into the memory data register (MDR).
- On reads with an instruction-write request, it also loads the instruction register (IR) that feeds the controller's `instruction` input.
- It reports `busy`/`done` so the controller can hold in its memory states.

---
 rtl/mem_port_pkg.sv | 17 +
 rtl/word_byte_lane.sv | 35 +++
 rtl/memory_port.sv | 141 ++++++++++++++
 tb/tb_memory_port.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the multicycle memory front end.
package mem_port_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte beats per 32-bit word over the 8-bit external bus.
  localparam int BEATS  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = BEATS * LANE_W;

endpackage

// File: rtl/word_byte_lane.sv
// Byte-lane helper: picks a byte out of a word for the write path and
// inserts an incoming byte into an assembly register for the read path.
module word_byte_lane #(
  parameter int BEATS  = 4,
  parameter int LANE_W = 8
) (
  input  logic                        clk,
  input  logic [BEATS*LANE_W-1:0]     word,
  input  logic [$clog2(BEATS)-1:0]    rd_idx,
  output logic [LANE_W-1:0]           rd_byte,
  input  logic                        ins_en,
  input  logic [$clog2(BEATS)-1:0]    ins_idx,
  input  logic [LANE_W-1:0]           ins_byte,
  output logic [BEATS*LANE_W-1:0]     asm_next
);

  logic [BEATS*LANE_W-1:0] asm_q;

  // Little-endian lane select: index 0 is bits [LANE_W-1:0].
  assign rd_byte = word[rd_idx*LANE_W +: LANE_W];

  // Assembly word with the current byte already merged, so the final beat
  // can be committed to MDR on the same edge that accepts it.
  always_comb begin
    asm_next = asm_q;
    asm_next[ins_idx*LANE_W +: LANE_W] = ins_byte;
  end

  // Assembly register holds bytes of an in-flight read; every byte is
  // rewritten before completion, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (ins_en) asm_q <= asm_next;
  end

endmodule

// File: rtl/memory_port.sv
// Multicycle memory front end: captures a one-cycle read/write request,
// performs it as byte beats on an 8-bit handshake bus, and holds MDR/IR.
module memory_port #(
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic [31:0] alu_addr,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] write_data,
  output logic [31:0] instruction,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        req_err,
  output logic [31:0] ext_addr,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack
);
  import mem_port_pkg::*;

  localparam int KW = $clog2(BEATS);

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_nxt;
  logic [31:0]     base;
  logic [31:0]     wdata_q;
  logic            irw_q;
  logic [31:0]     req_base;
  logic            req_ok;
  logic [31:0]     lane_word;
  logic [KW-1:0]   lane_idx;
  logic [7:0]      lane_byte;
  logic [31:0]     asm_next;

  assign k_nxt    = k + KW'(1);
  assign req_base = (IorD ? alu_addr : pc_addr) & 32'hFFFF_FFFC;
  assign req_ok   = (state == IDLE) && (MemRead ^ MemWrite);

  // In IDLE the first byte comes straight from the request; afterwards the
  // next beat's byte is taken from the latched store data.
  assign lane_word = (state == IDLE) ? write_data : wdata_q;
  assign lane_idx  = (state == IDLE) ? '0 : k_nxt;

  word_byte_lane #(
    .BEATS  (BEATS),
    .LANE_W (LANE_W)
  ) u_lane (
    .clk      (clk),
    .word     (lane_word),
    .rd_idx   (lane_idx),
    .rd_byte  (lane_byte),
    .ins_en   ((state == RD) && ext_ack),
    .ins_idx  (k),
    .ins_byte (ext_rdata),
    .asm_next (asm_next)
  );

  // Request operands are held for the whole access; captured only on accept.
  always_ff @(posedge clk) begin
    if (req_ok) begin
      base    <= req_base;
      wdata_q <= write_data;
      irw_q   <= IRWrite;
    end
  end

  // Access sequencer with registered bus strobes, status pulses, MDR and IR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      ext_rd      <= 1'b0;
      ext_wr      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_err     <= 1'b0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
      instruction <= '0;
      mdr         <= '0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          if (MemRead && MemWrite) begin
            req_err <= 1'b1;
          end else if (MemRead) begin
            state    <= RD;
            k        <= '0;
            ext_rd   <= 1'b1;
            busy     <= 1'b1;
            ext_addr <= req_base;
          end else if (MemWrite) begin
            state     <= WR;
            k         <= '0;
            ext_wr    <= 1'b1;
            busy      <= 1'b1;
            ext_addr  <= req_base;
            ext_wdata <= lane_byte;
          end
        end
        RD, WR: begin
          if (ext_ack) begin
            if (k == KW'(BEATS - 1)) begin
              state  <= DONE;
              ext_rd <= 1'b0;
              ext_wr <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              if (state == RD) begin
                mdr <= asm_next;
                if (irw_q) instruction <= asm_next;
              end
            end else begin
              k        <= k_nxt;
              ext_addr <= base + 32'(k_nxt);
              if (state == WR) ext_wdata <= lane_byte;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port.sv
// Self-checking bench for memory_port: directed scenarios plus randomized
// traffic against a transaction-level model of the access rules.
`timescale 1ns/1ps
module tb_memory_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_addr = '0, alu_addr = '0, write_data = '0;
  logic        IorD = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, IRWrite = 1'b0;
  logic [31:0] instruction, mdr, ext_addr;
  logic        busy, done, req_err, ext_rd, ext_wr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata = '0;
  logic        ext_ack = 1'b0;

  memory_port #(.BEATS(4)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .alu_addr(alu_addr), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .write_data(write_data), .instruction(instruction), .mdr(mdr), .busy(busy),
    .done(done), .req_err(req_err), .ext_addr(ext_addr), .ext_rd(ext_rd),
    .ext_wr(ext_wr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave memory ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  int wait_mode = 0;   // fixed wait cycles per beat, or -1 for random 0..3
  bit stray_ack = 0;
  int wait_left = 0;
  bit in_beat = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        in_beat = 0;
        ext_ack = 1'b0;
      end else if (ext_rd || ext_wr) begin
        if (!in_beat) begin
          in_beat = 1;
          wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
        if (wait_left == 0) begin
          ext_ack = 1'b1;
          in_beat = 0;
          if (ext_rd) ext_rdata = mem_rd(ext_addr);
          else mem[ext_addr] = ext_wdata;
        end else begin
          wait_left--;
          ext_ack = 1'b0;
          ext_rdata = 8'($urandom);
        end
      end else begin
        ext_ack = stray_ack ? 1'($urandom_range(0, 1)) : 1'b0;
        ext_rdata = 8'($urandom);
      end
    end
  end

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  wb;
  } beat_t;

  beat_t       mq[$];
  bit          m_rd, m_irw, m_done, m_err, m_prev_done;
  logic [31:0] m_word, m_mdr = '0, m_ir = '0, m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_done = 0;
      m_err = 0;
      m_mdr = '0;
      m_ir = '0;
    end else begin
      m_prev_done = m_done;
      m_done = 0;
      m_err = 0;
      if (mq.size() > 0) begin
        if (ext_ack) begin
          void'(mq.pop_front());
          if (mq.size() == 0) begin
            m_done = 1;
            if (m_rd) begin
              m_mdr = m_word;
              if (m_irw) m_ir = m_word;
            end
          end
        end
      end else if (!m_prev_done) begin
        if (MemRead && MemWrite) begin
          m_err = 1;
        end else if (MemRead || MemWrite) begin
          m_b = (IorD ? alu_addr : pc_addr) & 32'hFFFF_FFFC;
          for (int i = 0; i < 4; i++) begin
            beat_t e;
            e.addr = m_b + 32'(i);
            e.wb = 8'(write_data >> (8 * i));
            mq.push_back(e);
          end
          m_rd = MemRead;
          m_irw = IRWrite;
          m_word = {mem_rd(m_b + 3), mem_rd(m_b + 2), mem_rd(m_b + 1), mem_rd(m_b)};
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("busy", 32'(busy), 32'(mq.size() > 0));
      chk("ext_rd", 32'(ext_rd), 32'(mq.size() > 0 && m_rd));
      chk("ext_wr", 32'(ext_wr), 32'(mq.size() > 0 && !m_rd));
      chk("done", 32'(done), 32'(m_done));
      chk("req_err", 32'(req_err), 32'(m_err));
      chk("mdr", mdr, m_mdr);
      chk("instruction", instruction, m_ir);
      if (mq.size() > 0) begin
        chk("ext_addr", ext_addr, mq[0].addr);
        if (!m_rd) chk("ext_wdata", 32'(ext_wdata), 32'(mq[0].wb));
      end
    end
  end

  // Record accepted beats and write-strobe cycles for directed checks.
  logic [31:0] seen_addr[$];
  logic [7:0]  seen_wb[$];
  int          wr_cycles = 0;

  always @(posedge clk) begin
    if (!rst && (ext_rd || ext_wr) && ext_ack) begin
      seen_addr.push_back(ext_addr);
      if (ext_wr) seen_wb.push_back(ext_wdata);
    end
  end

  always @(negedge clk) begin
    if (ext_wr) wr_cycles++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input logic rd, input logic wr, input logic irw, input logic iord,
                     input logic [31:0] pa, input logic [31:0] aa, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; IRWrite = irw; IorD = iord;
    pc_addr = pa; alu_addr = aa; write_data = wd;
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0; IRWrite = 0; IorD = ~iord;
    pc_addr = $urandom; alu_addr = $urandom; write_data = $urandom;
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic clear_seen();
    seen_addr.delete();
    seen_wb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  int wr_before;
  int r;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_req_err", 32'(req_err), 0);
    chk("rst_ext_rd", 32'(ext_rd), 0);
    chk("rst_ext_wr", 32'(ext_wr), 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_wdata", 32'(ext_wdata), 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_instruction", instruction, 0);
    @(negedge clk);
    rst = 1'b0;
    started = 1;
    @(posedge clk); #1;

    // Instruction fetch, ack tied high.
    mem[32'h10] = 8'h20; mem[32'h11] = 8'h10; mem[32'h12] = 8'h44; mem[32'h13] = 8'h01;
    clear_seen();
    req(1, 0, 1, 0, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0);
    wait_done(1, n);
    chk("fetch_done_cycle", 32'(n), 5);
    chk("fetch_instruction", instruction, 32'h0144_1020);
    chk("fetch_mdr", mdr, 32'h0144_1020);
    chk("fetch_beats", 32'(seen_addr.size()), 4);
    for (int i = 0; i < 4 && i < seen_addr.size(); i++)
      chk("fetch_addr", seen_addr[i], 32'h10 + 32'(i));
    @(posedge clk); #1;

    // Misaligned load with two wait cycles per beat.
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    wait_mode = 2;
    clear_seen();
    req(1, 0, 0, 1, 32'h0000_0010, 32'h0000_0103, 32'h0);
    wait_done(1, n);
    chk("load_done_cycle", 32'(n), 13);
    chk("load_mdr", mdr, 32'h1234_5678);
    chk("load_instruction_held", instruction, 32'h0144_1020);
    chk("load_beats", 32'(seen_addr.size()), 4);
    for (int i = 0; i < 4 && i < seen_addr.size(); i++)
      chk("load_addr", seen_addr[i], 32'h100 + 32'(i));
    wait_mode = 0;
    @(posedge clk); #1;

    // Store.
    clear_seen();
    req(0, 1, 0, 1, 32'h0000_0010, 32'h0000_0020, 32'hDEAD_BEEF);
    wait_done(1, n);
    chk("store_done_cycle", 32'(n), 5);
    chk("store_beats", 32'(seen_wb.size()), 4);
    if (seen_wb.size() == 4) begin
      chk("store_b0", 32'(seen_wb[0]), 32'hEF);
      chk("store_b1", 32'(seen_wb[1]), 32'hBE);
      chk("store_b2", 32'(seen_wb[2]), 32'hAD);
      chk("store_b3", 32'(seen_wb[3]), 32'hDE);
      chk("store_a0", seen_addr[0], 32'h20);
      chk("store_a3", seen_addr[3], 32'h23);
    end
    chk("store_mdr_held", mdr, 32'h1234_5678);
    chk("store_instruction_held", instruction, 32'h0144_1020);
    @(posedge clk); #1;

    // Illegal request.
    req(1, 1, 1, 0, 32'h0000_0040, 32'h0000_0040, 32'h0);
    chk("illegal_req_err", 32'(req_err), 1);
    chk("illegal_busy", 32'(busy), 0);
    chk("illegal_ext_rd", 32'(ext_rd), 0);
    chk("illegal_ext_wr", 32'(ext_wr), 0);
    @(posedge clk); #1;
    chk("illegal_req_err_pulse", 32'(req_err), 0);
    chk("illegal_busy_after", 32'(busy), 0);

    // Reset after beat 1 of a fetch.
    req(1, 0, 1, 0, 32'h0000_0010, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ext_rd", 32'(ext_rd), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_instruction", instruction, 0);
    chk("midrst_mdr", mdr, 0);
    chk("midrst_ext_addr", ext_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mem[32'h50] = 8'h13; mem[32'h51] = 8'h05; mem[32'h52] = 8'hA0; mem[32'h53] = 8'h00;
    req(1, 0, 1, 0, 32'h0000_0052, 32'h0, 32'h0);
    wait_done(1, n);
    chk("refetch_done_cycle", 32'(n), 5);
    chk("refetch_instruction", instruction, 32'h00A0_0513);
    @(posedge clk); #1;

    // Write strobe during an active read is ignored.
    clear_seen();
    wr_before = wr_cycles;
    req(1, 0, 0, 0, 32'h0000_0050, 32'h0, 32'h0);
    MemWrite = 1; write_data = 32'hCAFE_F00D; alu_addr = 32'h60; IorD = 1;
    @(posedge clk); #1;
    MemWrite = 0;
    wait_done(2, n);
    chk("busyreq_done_cycle", 32'(n), 5);
    chk("busyreq_no_wr", 32'(wr_cycles - wr_before), 0);
    chk("busyreq_beats", 32'(seen_addr.size()), 4);
    chk("busyreq_mdr", mdr, 32'h00A0_0513);
    @(posedge clk); #1;

    // Randomized traffic with random wait states and stray acks.
    wait_mode = -1;
    stray_ack = 1;
    repeat (1500) begin
      r = $urandom_range(0, 9);
      MemRead  = (r < 3) || (r == 9);
      MemWrite = (r >= 3 && r < 5) || (r == 9);
      IRWrite  = 1'($urandom);
      IorD     = 1'($urandom);
      pc_addr  = $urandom_range(0, 255);
      alu_addr = $urandom_range(0, 255);
      write_data = $urandom;
      @(posedge clk); #1;
    end
    MemRead = 0; MemWrite = 0;
    repeat (40) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
